// File: rtl/dense_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dense_pkg
// Description : Shared constants for the dense layer: bias word width, output
//               length, address-width helper and bias loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dense_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int DENSE_OUT_LEN = 10;

  // Loader state encoding, shared with the dense-layer controller.
  localparam logic [1:0] LDR_IDLE  = 2'd0;
  localparam logic [1:0] LDR_LOAD  = 2'd1;
  localparam logic [1:0] LDR_CHECK = 2'd2;
  localparam logic [1:0] LDR_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = LDR_IDLE,
    ST_LOAD  = LDR_LOAD,
    ST_CHECK = LDR_CHECK,
    ST_DONE  = LDR_DONE
  } loader_state_t;

  // Number of address bits needed to index n entries (ceil(log2(n))).
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dense_bias_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : dense_bias_loader_if
// Description : Bias stream, read port and status signals of the bias loader.
//               master = host/consumer side, slave = loader side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dense_bias_loader_if #(
  parameter int WORD_SIZE = dense_pkg::WORD_SIZE,
  parameter int ADR_SIZE  = dense_pkg::clogb2(dense_pkg::DENSE_OUT_LEN)
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic [ADR_SIZE-1:0]  rd_adr;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, in_valid, in_data, rd_adr,
    input  in_ready, rd_data, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_data, rd_adr,
    output in_ready, rd_data, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/bias_regfile.sv
`default_nettype none
// ============================================================================
// Module      : bias_regfile
// Description : LENGTH_SIZE x WORD_SIZE bias storage. Synchronous write,
//               registered read (read-before-write), out-of-range reads
//               return zero, whole array cleared by asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bias_regfile #(
  parameter int WORD_SIZE   = 32,
  parameter int LENGTH_SIZE = 10,
  parameter int ADR_SIZE    = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 i_wr_en,
  input  wire logic [ADR_SIZE-1:0]  i_wr_adr,
  input  wire logic [WORD_SIZE-1:0] i_wr_data,
  input  wire logic [ADR_SIZE-1:0]  i_rd_adr,
  output logic      [WORD_SIZE-1:0] o_rd_data
);

  localparam logic [ADR_SIZE-1:0] c_last_adr = ADR_SIZE'(LENGTH_SIZE - 1);

  logic [WORD_SIZE-1:0] r_mem [LENGTH_SIZE];
  logic [WORD_SIZE-1:0] r_rd_data;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;

  assign w_wr_in_range = (i_wr_adr <= c_last_adr);
  assign w_rd_in_range = (i_rd_adr <= c_last_adr);

  // Storage write and registered read; the read samples the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LENGTH_SIZE; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (i_wr_en && w_wr_in_range) begin
        r_mem[i_wr_adr] <= i_wr_data;
      end
      r_rd_data <= w_rd_in_range ? r_mem[i_rd_adr] : '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/dense_bias_loader.sv
`default_nettype none
// ============================================================================
// Module      : dense_bias_loader
// Description : Run-time loader for the dense-layer bias table. Accepts
//               LENGTH_SIZE words over a valid/ready stream, stores them in
//               order and serves them through a registered read port.
//               Optional feature macro: DENSE_BIAS_CHECKSUM_EN (adds a
//               trailing checksum word compared against the running sum).
// Revision    : 1.0 - initial release
// ============================================================================
module dense_bias_loader #(
  parameter int WORD_SIZE   = dense_pkg::WORD_SIZE,
  parameter int LENGTH_SIZE = dense_pkg::DENSE_OUT_LEN
) (
  input wire logic            clk,
  input wire logic            rst_n,
  dense_bias_loader_if.slave  bus
);
  import dense_pkg::*;

  localparam int ADR_SIZE = clogb2(LENGTH_SIZE);
  localparam logic [ADR_SIZE-1:0] c_last_adr = ADR_SIZE'(LENGTH_SIZE - 1);

  loader_state_t        r_state;
  logic [ADR_SIZE-1:0]  r_wr_ptr;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_wr_en;
`ifdef DENSE_BIAS_CHECKSUM_EN
  logic                 r_err;
  logic [WORD_SIZE-1:0] r_sum;
`endif

  assign w_accept = bus.in_valid && r_in_ready;
  // The checksum word arrives in CHECK and is never stored.
  assign w_wr_en  = w_accept && (r_state == ST_LOAD);

  // Loader FSM: pointer, handshake and status flags are all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DENSE_BIAS_CHECKSUM_EN
      r_err      <= 1'b0;
      r_sum      <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state    <= ST_LOAD;
            r_wr_ptr   <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
`ifdef DENSE_BIAS_CHECKSUM_EN
            r_err      <= 1'b0;
            r_sum      <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
`ifdef DENSE_BIAS_CHECKSUM_EN
            r_sum <= r_sum + bus.in_data;
`endif
            if (r_wr_ptr == c_last_adr) begin
              r_wr_ptr <= '0;
`ifdef DENSE_BIAS_CHECKSUM_EN
              r_state  <= ST_CHECK;
`else
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
`endif
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
`ifdef DENSE_BIAS_CHECKSUM_EN
        ST_CHECK: begin
          if (w_accept) begin
            r_state    <= ST_DONE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= (bus.in_data != r_sum);
          end
        end
`endif
        default: begin
          r_state    <= ST_IDLE;
          r_wr_ptr   <= '0;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  bias_regfile #(
    .WORD_SIZE   (WORD_SIZE),
    .LENGTH_SIZE (LENGTH_SIZE),
    .ADR_SIZE    (ADR_SIZE)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_adr  (r_wr_ptr),
    .i_wr_data (bus.in_data),
    .i_rd_adr  (bus.rd_adr),
    .o_rd_data (bus.rd_data)
  );

  assign bus.in_ready = r_in_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
`ifdef DENSE_BIAS_CHECKSUM_EN
  assign bus.err      = r_err;
`else
  assign bus.err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dense_bias_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dense_bias_loader
// Description : Self-checking bench for dense_bias_loader: table-driven read
//               checks plus directed sequences for gaps, ignored start,
//               mid-load reset, read-before-write and the checksum option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_bias_loader;

  typedef struct {
    logic [3:0]  adr;
    logic [31:0] exp;
  } rd_vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dense_bias_loader_if bus ();

  dense_bias_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] w1 [10];
  logic [31:0] w2 [10];
  logic [31:0] w3 [10];
  logic [31:0] w5 [10];
  rd_vec_t     t1 [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Present one word and hold it until the handshake completes (bounded).
  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_word_timeout got=in_ready_low want=in_ready_high");
    end else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] adr, input logic [31:0] exp);
    bus.rd_adr = adr;
    @(posedge clk); #1;
    check(name, bus.rd_data, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    w1 = '{32'h012598B0, 32'h0B1A26D0, 32'h1C2D3E4F, 32'h7FFFFFFF, 32'h80000000,
           32'hFFFFFFFF, 32'h00000001, 32'h5A5AA5A5, 32'hDEADBEEF, 32'hFFA37200};
    for (int i = 0; i < 10; i++) begin
      w2[i] = 32'hA000_0000 + 32'(i);
      w3[i] = 32'hC000_0000 + 32'(i);
      w5[i] = 32'hB000_0000 + 32'(i);
      t1[i] = '{adr: 4'(i), exp: w1[i]};
    end
    t1[10] = '{adr: 4'd12, exp: 32'h0};
    t1[11] = '{adr: 4'd15, exp: 32'h0};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rd_adr   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_busy",     32'(bus.busy),     32'h0);
    check("rst_done",     32'(bus.done),     32'h0);
    check("rst_err",      32'(bus.err),      32'h0);
    check("rst_rd_data",  bus.rd_data,       32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: back-to-back load; valid already high on the start edge.
    bus.in_valid = 1'b1;
    bus.in_data  = w1[0];
    pulse_start();
    check("t1_in_ready_after_start", 32'(bus.in_ready), 32'h1);
    check("t1_busy_after_start",     32'(bus.busy),     32'h1);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) check("t1_done_before_last", 32'(bus.done), 32'h0);
      send_word(w1[i]);
    end
`ifndef DENSE_BIAS_CHECKSUM_EN
    check("t1_done",     32'(bus.done),     32'h1);
    check("t1_busy_end", 32'(bus.busy),     32'h0);
    check("t1_ready_end", 32'(bus.in_ready), 32'h0);
`else
    send_word(32'h0);
    check("t1_done", 32'(bus.done), 32'h1);
`endif
    for (int i = 0; i < 12; i++) read_check("t1_read", t1[i].adr, t1[i].exp);

    // 2: start in DONE clears done; then a load with valid gaps.
    pulse_start();
    check("t2_done_cleared", 32'(bus.done), 32'h0);
    check("t2_busy",         32'(bus.busy), 32'h1);
    for (int i = 0; i < 10; i++) begin
      send_word(w2[i]);
      if (i < 9 && (i % 2) == 0) begin
        @(posedge clk); #1;
        check("t2_done_early", 32'(bus.done), 32'h0);
      end
    end
`ifdef DENSE_BIAS_CHECKSUM_EN
    send_word(32'h0);
`endif
    check("t2_done", 32'(bus.done), 32'h1);
    for (int i = 0; i < 10; i++) read_check("t2_read", 4'(i), w2[i]);

    // 3: start pulsed mid-load is ignored.
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        pulse_start();
        check("t3_busy_after_restart",  32'(bus.busy),     32'h1);
        check("t3_ready_after_restart", 32'(bus.in_ready), 32'h1);
        check("t3_done_after_restart",  32'(bus.done),     32'h0);
      end
      send_word(w3[i]);
    end
`ifdef DENSE_BIAS_CHECKSUM_EN
    send_word(32'h0);
`endif
    check("t3_done", 32'(bus.done), 32'h1);
    for (int i = 0; i < 10; i++) read_check("t3_read", 4'(i), w3[i]);

    // 4: asynchronous reset after 4 words of a new load.
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(w5[i]);
    bus.rd_adr = 4'd7;
    #3 rst_n = 1'b0;
    #1;
    check("t4_rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("t4_rst_busy",     32'(bus.busy),     32'h0);
    check("t4_rst_done",     32'(bus.done),     32'h0);
    check("t4_rst_rd_data",  bus.rd_data,       32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) read_check("t4_read_zero", 4'(i), 32'h0);
    read_check("t4_read_zero_adr7", 4'd7, 32'h0);

    // 5: read-before-write on address 3.
    pulse_start();
    for (int i = 0; i < 10; i++) send_word(w1[i]);
`ifdef DENSE_BIAS_CHECKSUM_EN
    send_word(32'h0);
`endif
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(w5[i]);
    bus.rd_adr   = 4'd3;
    bus.in_valid = 1'b1;
    bus.in_data  = w5[3];
    @(posedge clk); #1;
    check("t5_rbw_old", bus.rd_data, w1[3]);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_rbw_new", bus.rd_data, w5[3]);
    for (int i = 4; i < 10; i++) send_word(w5[i]);
`ifdef DENSE_BIAS_CHECKSUM_EN
    send_word(32'h0);
`endif
    check("t5_done", 32'(bus.done), 32'h1);
    read_check("t5_oor_adr12", 4'd12, 32'h0);

    // 6: checksum option.
`ifdef DENSE_BIAS_CHECKSUM_EN
    pulse_start();
    for (int i = 1; i <= 10; i++) send_word(32'(i));
    check("t6_check_ready", 32'(bus.in_ready), 32'h1);
    check("t6_check_done",  32'(bus.done),     32'h0);
    check("t6_check_busy",  32'(bus.busy),     32'h1);
    send_word(32'd55);
    check("t6_good_done", 32'(bus.done), 32'h1);
    check("t6_good_err",  32'(bus.err),  32'h0);
    pulse_start();
    for (int i = 1; i <= 10; i++) send_word(32'(i));
    send_word(32'd54);
    check("t6_bad_done", 32'(bus.done), 32'h1);
    check("t6_bad_err",  32'(bus.err),  32'h1);
    pulse_start();
    check("t6_err_cleared", 32'(bus.err), 32'h0);
    for (int i = 1; i <= 10; i++) send_word(32'(i));
    send_word(32'd55);
    check("t6_final_err", 32'(bus.err), 32'h0);
    read_check("t6_read_adr9", 4'd9, 32'd10);
`else
    pulse_start();
    for (int i = 1; i <= 10; i++) send_word(32'(i));
    check("t6_done", 32'(bus.done), 32'h1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd55;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_extra_ready", 32'(bus.in_ready), 32'h0);
    check("t6_err_zero",       32'(bus.err),      32'h0);
    check("t6_done_held",      32'(bus.done),     32'h1);
    bus.in_valid = 1'b0;
    read_check("t6_read_adr0", 4'd0, 32'd1);
    read_check("t6_read_adr9", 4'd9, 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
